// File: rtl/isp_frame_ctrl.sv
// Frame sequencer for the ISP pipeline: accepts one frame of 2-pixel beats,
// drives the pipeline clock enable and tracks per-beat markers through the pipe.
module isp_frame_ctrl #(
    parameter int FRAME_W  = 960,
    parameter int FRAME_H  = 1080,
    parameter int PIPE_LAT = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [35:0] cfg_offset,
    input  logic [35:0] cfg_gain,
    input  logic        src_valid,
    output logic        src_ready,
    input  logic [71:0] src_pixel,
    input  logic        sink_ready,
    output logic [71:0] pipe_pixel,
    output logic [35:0] pipe_offset,
    output logic [35:0] pipe_gain,
    output logic        pipe_en,
    output logic        out_valid,
    output logic        out_sof,
    output logic        out_eol,
    output logic        out_eof,
    output logic [11:0] x_cnt,
    output logic [11:0] y_cnt,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_next;

    logic [35:0]         shadow_offset, shadow_gain;
    logic [PIPE_LAT-1:0] tag_valid, tag_eol, tag_eof, tag_sof;
    logic                accept, transfer, x_last, y_last, frame_last;
    logic                start_ok, done_next;

    assign busy        = (state != IDLE);
    assign src_ready   = (state == RUN) & sink_ready;
    assign accept      = src_valid & src_ready;
    assign pipe_en     = sink_ready & busy;
    assign pipe_pixel  = accept ? src_pixel : 72'h0;
    assign pipe_offset = shadow_offset;
    assign pipe_gain   = shadow_gain;

    assign x_last     = (x_cnt == 12'(FRAME_W - 1));
    assign y_last     = (y_cnt == 12'(FRAME_H - 1));
    assign frame_last = x_last & y_last;

    assign out_valid = tag_valid[PIPE_LAT-1];
    assign out_sof   = tag_sof[PIPE_LAT-1];
    assign out_eol   = tag_eol[PIPE_LAT-1];
    assign out_eof   = tag_eof[PIPE_LAT-1];
    assign transfer  = out_valid & sink_ready;

    // The done cycle is already IDLE, so a start landing on it must be masked
    assign start_ok = (state == IDLE) & start & ~done;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_ok) state_next = RUN;
                RUN:     if (accept && frame_last) state_next = DRAIN;
                DRAIN: begin
                    if (transfer && out_eof) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shadow_offset <= '0;
            shadow_gain   <= '0;
            x_cnt         <= '0;
            y_cnt         <= '0;
            tag_valid     <= '0;
            tag_eol       <= '0;
            tag_eof       <= '0;
            tag_sof       <= '0;
            done          <= 1'b0;
        end else if (abort) begin
            x_cnt     <= '0;
            y_cnt     <= '0;
            tag_valid <= '0;
            tag_eol   <= '0;
            tag_eof   <= '0;
            tag_sof   <= '0;
            done      <= 1'b0;
        end else begin
            done <= done_next;
            if (start_ok) begin
                shadow_offset <= cfg_offset;
                shadow_gain   <= cfg_gain;
                x_cnt         <= '0;
                y_cnt         <= '0;
                tag_valid     <= '0;
                tag_eol       <= '0;
                tag_eof       <= '0;
                tag_sof       <= '0;
            end else begin
                // Tags advance in lockstep with the pipeline enable so a stall loses nothing
                if (pipe_en) begin
                    for (int i = PIPE_LAT - 1; i > 0; i--) begin
                        tag_valid[i] <= tag_valid[i-1];
                        tag_eol[i]   <= tag_eol[i-1];
                        tag_eof[i]   <= tag_eof[i-1];
                        tag_sof[i]   <= tag_sof[i-1];
                    end
                    tag_valid[0] <= accept;
                    tag_eol[0]   <= accept & x_last;
                    tag_eof[0]   <= accept & frame_last;
                    tag_sof[0]   <= accept & (x_cnt == 12'd0) & (y_cnt == 12'd0);
                end
                if (accept) begin
                    if (x_last) begin
                        x_cnt <= '0;
                        y_cnt <= y_last ? 12'd0 : y_cnt + 12'd1;
                    end else begin
                        x_cnt <= x_cnt + 12'd1;
                    end
                end
            end
        end
    end

endmodule
